// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and default widths for the SPI clock generator
package spi_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int DEF_DIV_W = 16;
  localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: programmable SPI SCLK divider with CPOL and edge strobes; optional period count via SPI_SCLK_GEN_EDGE_CNT_EN
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] half_period,
  input  logic             cpol,
`ifdef SPI_SCLK_GEN_EDGE_CNT_EN
  input  logic [CNT_W-1:0] n_periods,
  output logic             done,
`endif
  output logic             sclk_out,
  output logic             lead_stb,
  output logic             trail_stb,
  output logic             busy
);
  if (DIV_W < 1 || CNT_W < 1) begin : g_param_chk
    $error("spi_sclk_gen: DIV_W and CNT_W must be at least 1");
  end
  state_t state, state_n;
  logic [DIV_W-1:0] cnt, cnt_n, hp, hp_n;
  logic cpol_l, cpol_n, sclk_n, lead_n, trail_n, busy_n, wrap, start;
  assign wrap = cnt == hp - DIV_W'(1);
`ifdef SPI_SCLK_GEN_EDGE_CNT_EN
  logic [CNT_W-1:0] np, np_n, per_cnt, per_n;
  logic done_n, hold, hold_n;
  assign start = en & ~hold;
`else
  assign start = en;
`endif
  // next-state and next-output logic; a stop is only taken at a leading boundary so no phase is truncated
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    hp_n = hp;
    cpol_n = cpol_l;
    sclk_n = sclk_out;
    lead_n = 1'b0;
    trail_n = 1'b0;
    busy_n = busy;
`ifdef SPI_SCLK_GEN_EDGE_CNT_EN
    np_n = np;
    per_n = per_cnt;
    done_n = 1'b0;
    hold_n = hold & en;
`endif
    if (state == IDLE) begin
      sclk_n = cpol;
      if (start) begin
        state_n = RUN;
        busy_n = 1'b1;
        cnt_n = '0;
        hp_n = (half_period == '0) ? DIV_W'(1) : half_period;
        cpol_n = cpol;
`ifdef SPI_SCLK_GEN_EDGE_CNT_EN
        np_n = (n_periods == '0) ? CNT_W'(1) : n_periods;
        per_n = '0;
`endif
      end
    end else begin
      cnt_n = wrap ? '0 : cnt + DIV_W'(1);
      if (wrap && sclk_out == cpol_l) begin
        if (en) begin
          sclk_n = ~sclk_out;
          lead_n = 1'b1;
        end else begin
          state_n = IDLE;
          busy_n = 1'b0;
        end
      end else if (wrap) begin
        sclk_n = ~sclk_out;
        trail_n = 1'b1;
`ifdef SPI_SCLK_GEN_EDGE_CNT_EN
        per_n = per_cnt + CNT_W'(1);
        if (per_n == np) begin
          state_n = IDLE;
          busy_n = 1'b0;
          done_n = 1'b1;
          hold_n = 1'b1;
        end
`endif
      end
    end
  end
  // state and registered outputs with synchronous active-low reset
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      hp <= DIV_W'(1);
      cpol_l <= 1'b0;
      sclk_out <= 1'b0;
      lead_stb <= 1'b0;
      trail_stb <= 1'b0;
      busy <= 1'b0;
`ifdef SPI_SCLK_GEN_EDGE_CNT_EN
      np <= CNT_W'(1);
      per_cnt <= '0;
      done <= 1'b0;
      hold <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      hp <= hp_n;
      cpol_l <= cpol_n;
      sclk_out <= sclk_n;
      lead_stb <= lead_n;
      trail_stb <= trail_n;
      busy <= busy_n;
`ifdef SPI_SCLK_GEN_EDGE_CNT_EN
      np <= np_n;
      per_cnt <= per_n;
      done <= done_n;
      hold <= hold_n;
`endif
    end
  end
endmodule

// File: doc/spi_sclk_gen.md
# spi_sclk_gen

Parametrised SPI serial-clock generator, the successor to the fixed-ratio clock divider. It divides the system clock by a runtime-programmable half-period and selects idle polarity (CPOL) per run. It starts and stops only on clean edge boundaries and emits single-cycle leading/trailing edge strobes for the SPI shift/sample logic. It sits between the SPI control FSM and the shift register in the master driver.

## Interface
Parameters:
- DIV_W, 16, width of the half-period input and internal counter
- CNT_W, 8, width of the period-count input (used only with SPI_SCLK_GEN_EDGE_CNT_EN)

Ports:
- clk_in  in  1  system clock; all logic on its rising edge
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  run request; level-sensitive
- half_period  in  DIV_W  clk_in cycles per SCLK half-period; 0 treated as 1
- cpol  in  1  SCLK idle level
- sclk_out  out  1  registered serial clock
- lead_stb  out  1  one-cycle pulse in the cycle sclk_out leaves the idle level
- trail_stb  out  1  one-cycle pulse in the cycle sclk_out returns to the idle level
- busy  out  1  high while in RUN
- n_periods  in  CNT_W  SCLK periods per run (macro only; 0 treated as 1)
- done  out  1  one-cycle pulse on automatic stop (macro only)

## Operation
- States: IDLE, RUN. Reset (rst_n low at a clk_in edge): state IDLE, counter 0, sclk_out 0, lead_stb/trail_stb/busy/done 0.
- IDLE: sclk_out <= cpol every cycle. When en=1, latch hp = max(half_period,1) and cpol_l = cpol, counter <= 0, go to RUN, and set busy <= 1.
- RUN: counter increments each cycle. At counter == hp-1, the counter wraps to 0 and a boundary occurs:
  - sclk_out == cpol_l (leading boundary): if en=1, toggle sclk_out and pulse lead_stb. If en=0, do not toggle; go to IDLE with busy <= 0.
  - sclk_out != cpol_l (trailing boundary): always toggle back and pulse trail_stb. A stop never truncates a high/low phase.
- half_period and cpol are ignored during RUN. New values take effect only at the next IDLE→RUN.
- If en drops and rises again before the next leading boundary, the run continues uninterrupted.
- Counter arithmetic is unsigned DIV_W bits. hp-1 never underflows because hp ≥ 1.

## Timing
- en sampled high in IDLE at cycle 0 → busy=1 from cycle 1. The first lead edge on sclk_out and lead_stb appears at cycle hp+1 (with hp=1, at cycle 2).
- SCLK period: 2·hp clk_in cycles, with 50 % duty for every hp.
- Strobes are registered and coincide with the sclk_out transition. lead_stb and trail_stb are never high together.
- Stop latency: at most 2·hp cycles from en falling to busy=0. sclk_out equals cpol_l whenever busy falls.
- Reset mid-run: outputs take their reset values on the next clk_in edge and no strobe is emitted.

## Configuration
- SPI_SCLK_GEN_EDGE_CNT_EN defined:
  - n_periods and done exist.
  - n_periods is latched with hp.
  - A period counter increments on each trail_stb.
  - At the trail edge completing period n_periods, go to IDLE, drop busy, and pulse done in the same cycle as that trail_stb. This happens regardless of en.
  - en must return low before a new run is started; IDLE→RUN requires en=1.
- Not defined: ports absent and runs last while en=1.

## Structure
- Shared package spi_pkg: state enum (IDLE, RUN), default DIV_W/CNT_W constants.
- Single module; no sub-module. The half-period counter is simple enough to stay inline.

## Test plan
- Reset: hold rst_n=0 for 3 cycles mid-run (hp=4) → next edge sclk_out=0, busy=0, no strobes.
- half_period=3, cpol=0, en pulsed high for 20 cycles → period 6 cycles, 3 high/3 low. lead_stb on rises, trail_stb on falls, sclk_out ends at 0 with no partial phase.
- half_period=0 and 1, cpol=1 → both give period 2. sclk_out idles 1, first lead_stb at cycle 2, strobes alternate every cycle.
- en drops one cycle after a lead edge (hp=5) → high phase completes, trail_stb, busy falls 5 cycles later at the leading boundary. No extra lead_stb.
- half_period changed from 2 to 7 mid-run → period stays 4 until IDLE, next run period 14.
- Macro on, n_periods=8, hp=2, en held high → exactly 8 lead_stb and 8 trail_stb, done coincides with the 8th trail_stb, then busy=0. No restart until en toggles.
